// File: rtl/mandelbrot_link_defs.sv
// Shared definitions for the Mandelbrot block-render UART link.
// The renderer and the client both import this package, so opcodes, frame
// length and default geometry stay identical on both ends of the wire.
package mandelbrot_link_defs;

    // Link opcodes
    localparam logic [7:0] LINK_CMD_SEND_BUFFER = 8'h01;
    localparam logic [7:0] LINK_CMD_RESET       = 8'h02;

    // A request frame is the opcode followed by three 16-bit words, MSB first
    localparam int LINK_FRAME_LEN = 7;
    localparam int FRAME_IDX_W    = 3;

    // Default geometry and timing
    localparam int LINK_N          = 16;
    localparam int LINK_NC         = 8;
    localparam int LINK_BLOCK_SIZE = 64;
    localparam int LINK_TIMEOUT    = 1048576;

    // Client controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_GUARD,
        ST_SEND_WAIT,
        ST_RECV
    } client_state_e;

    // Byte `idx` of a request frame
    function automatic logic [7:0] frame_byte(
        input logic [FRAME_IDX_W-1:0] idx,
        input logic [7:0]             cmd,
        input logic [15:0]            c_real,
        input logic [15:0]            c_imag,
        input logic [15:0]            c_step
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = c_real[15:8];
            3'd2:    b = c_real[7:0];
            3'd3:    b = c_imag[15:8];
            3'd4:    b = c_imag[7:0];
            3'd5:    b = c_step[15:8];
            default: b = c_step[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mandelbrot_block_client.sv
// Initiator end of the block-render UART link. Serialises one block request
// onto uart_tx, then turns the BLOCK_SIZE x BLOCK_SIZE returned iteration
// counts into pixel strobes carrying their x/y position.
module mandelbrot_block_client
    import mandelbrot_link_defs::*;
#(
    parameter int         N               = LINK_N,
    parameter int         NC              = LINK_NC,
    parameter int         BLOCK_SIZE      = LINK_BLOCK_SIZE,
    parameter logic [7:0] CMD_SEND_BUFFER = LINK_CMD_SEND_BUFFER,
    parameter int         TIMEOUT         = LINK_TIMEOUT
) (
    input  logic          CLK,
    input  logic          RST_N,
    // Request side
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [N-1:0]  req_c_real,
    input  logic [N-1:0]  req_c_imag,
    input  logic [N-1:0]  req_c_step,
    // uart_tx side
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_active,
    // uart_rx side
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    // Pixel side
    output logic          pix_valid,
    output logic [7:0]    pix_x,
    output logic [7:0]    pix_y,
    output logic [NC-1:0] pix_count,
    // Status
    output logic          busy,
    output logic          done,
    output logic          err_timeout
);

    // x occupies the low bits of the pixel counter and y the next bits, so a
    // plain increment walks x first and carries into y on wrap.
    localparam int XW  = $clog2(BLOCK_SIZE);
    localparam int PCW = $clog2(BLOCK_SIZE * BLOCK_SIZE) + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [PCW-1:0]         LAST_PIX = PCW'(BLOCK_SIZE * BLOCK_SIZE - 1);
    localparam logic [TW-1:0]          TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(LINK_FRAME_LEN - 1);

    client_state_e          state_q, state_d;
    logic [FRAME_IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]           c_real_q, c_real_d;
    logic [N-1:0]           c_imag_q, c_imag_d;
    logic [N-1:0]           c_step_q, c_step_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [7:0]             pix_x_q, pix_x_d;
    logic [7:0]             pix_y_q, pix_y_d;
    logic [NC-1:0]          pix_count_q, pix_count_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;

    // Next-state and registered-output logic for the whole controller
    always_comb begin
        // NOTE: every target gets a default before the case so that no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        c_real_d    = c_real_q;
        c_imag_d    = c_imag_q;
        c_step_d    = c_step_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_count_d = pix_count_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pix_cnt_d   = pix_cnt_q;
        to_cnt_d    = to_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Stray rx bytes are ignored here by construction
                if (req_valid) begin
                    c_real_d = req_c_real;
                    c_imag_d = req_c_imag;
                    c_step_d = req_c_step;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!tx_active) begin
                    tx_data_d  = frame_byte(idx_q, CMD_SEND_BUFFER, 16'(c_real_q),
                                            16'(c_imag_q), 16'(c_step_q));
                    tx_start_d = 1'b1;
                    state_d    = ST_SEND_GUARD;
                end
            end

            // uart_tx raises tx_active only after it has seen the strobe, so
            // tx_active is not trusted during this single cycle.
            ST_SEND_GUARD: begin
                state_d = ST_SEND_WAIT;
            end

            ST_SEND_WAIT: begin
                if (!tx_active) begin
                    if (idx_q == LAST_IDX) begin
                        pix_cnt_d = '0;
                        to_cnt_d  = '0;
                        state_d   = ST_RECV;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end

            ST_RECV: begin
                if (done_q) begin
                    // Last pixel has just been presented; leave one cycle later
                    state_d = ST_IDLE;
                end else if (rx_ready) begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = 8'(pix_cnt_q[XW-1:0]);
                    pix_y_d     = 8'(pix_cnt_q[2*XW-1:XW]);
                    pix_count_d = NC'(rx_data);
                    pix_cnt_d   = pix_cnt_q + 1'b1;
                    to_cnt_d    = '0;
                    done_d      = (pix_cnt_q == LAST_PIX);
                end else if (to_cnt_q == TO_LAST) begin
                    // Renderer went silent: drop the partial block
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            c_real_q    <= '0;
            c_imag_q    <= '0;
            c_step_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_count_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pix_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            c_real_q    <= c_real_d;
            c_imag_q    <= c_imag_d;
            c_step_q    <= c_step_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_count_q <= pix_count_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pix_cnt_q   <= pix_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_count   = pix_count_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mandelbrot_block_client.sv
// Scoreboard bench for mandelbrot_block_client: stimulus pushes expected tx
// bytes and pixels into queues, a negedge monitor (which also models uart_tx)
// pops and compares whenever the DUT strobes.
module tb_mandelbrot_block_client;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_c_real = '0;
    logic [15:0] req_c_imag = '0;
    logic [15:0] req_c_step = '0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_active = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [7:0]  pix_count;
    logic        busy;
    logic        done;
    logic        err_timeout;

    mandelbrot_block_client #(
        .TIMEOUT(64)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_c_real (req_c_real),
        .req_c_imag (req_c_imag),
        .req_c_step (req_c_step),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_active  (tx_active),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_count  (pix_count),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] c;
        logic       d;
    } pix_t;

    logic [7:0] exp_tx[$];
    pix_t       exp_pix[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pix_cyc = 0;
    int tx_busy_cnt = 0;
    bit to_armed = 1'b0;
    bit to_seen = 1'b0;
    bit rr_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart_tx model plus scoreboard monitor
    always @(negedge clk) begin : monitor
        pix_t e;
        cyc++;
        if (rr_next) begin
            check("req_ready_after_done", 32'(req_ready), 32'd1);
            rr_next = 1'b0;
        end
        if (tx_start) begin
            check("tx_start_while_active", 32'(tx_active), 32'd0);
            if (exp_tx.size() == 0) check("unexpected_tx_start", 32'(tx_start), 32'd0);
            else                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            tx_active   = 1'b1;
            tx_busy_cnt = 10;
        end else if (tx_busy_cnt > 0) begin
            tx_busy_cnt--;
            if (tx_busy_cnt == 0) tx_active = 1'b0;
        end
        if (pix_valid) begin
            if (exp_pix.size() == 0) begin
                check("unexpected_pix_valid", 32'(pix_valid), 32'd0);
            end else begin
                e = exp_pix.pop_front();
                check("pix_x_y_count_done", 32'({pix_x, pix_y, pix_count, done}), 32'(e));
                last_pix_cyc = cyc;
                if (done) rr_next = 1'b1;
            end
        end else if (done) begin
            check("done_without_pix_valid", 32'(done), 32'd0);
        end
        if (err_timeout) begin
            check("timeout_expected", 32'(to_armed), 32'd1);
            check("timeout_delay", 32'(cyc - last_pix_cyc), 32'd64);
            to_armed = 1'b0;
            to_seen  = 1'b1;
        end
    end

    task automatic push_frame(input logic [15:0] cr, input logic [15:0] ci, input logic [15:0] cs);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(cr[15:8]);
        exp_tx.push_back(cr[7:0]);
        exp_tx.push_back(ci[15:8]);
        exp_tx.push_back(ci[7:0]);
        exp_tx.push_back(cs[15:8]);
        exp_tx.push_back(cs[7:0]);
    endtask

    task automatic send_req(input logic [15:0] cr, input logic [15:0] ci, input logic [15:0] cs);
        int k;
        push_frame(cr, ci, cs);
        @(negedge clk);
        req_valid  = 1'b1;
        req_c_real = cr;
        req_c_imag = ci;
        req_c_step = cs;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_accepted", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_tx_left(input int n);
        int k = 0;
        while (exp_tx.size() > n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tx_progress", 32'(exp_tx.size()), 32'(n));
    endtask

    task automatic wait_frame_sent();
        int k = 0;
        while (!(exp_tx.size() == 0 && !tx_active) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("frame_sent", 32'(exp_tx.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data  = d;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic push_pix(input int x, input int y, input logic [7:0] c, input logic d);
        pix_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.c = c;
        p.d = d;
        exp_pix.push_back(p);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_tx_start"},    32'(tx_start), 32'd0);
        check({tag, "_tx_data"},     32'(tx_data), 32'd0);
        check({tag, "_pix_valid"},   32'(pix_valid), 32'd0);
        check({tag, "_pix_xy"},      32'({pix_x, pix_y}), 32'd0);
        check({tag, "_pix_count"},   32'(pix_count), 32'd0);
        check({tag, "_done"},        32'(done), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);
        check_reset_outputs("after_reset");

        // Stray byte while idle must not produce a pixel
        rx_byte(8'h55);
        repeat (3) @(negedge clk);

        // Frame A, then hold a second request while busy
        send_req(16'hF800, 16'hFC00, 16'h0010);
        req_valid  = 1'b1;
        req_c_real = 16'h0100;
        req_c_imag = 16'h0200;
        req_c_step = 16'h0004;
        check("hold_req_ready_send", 32'(req_ready), 32'd0);
        wait_tx_left(5);
        rx_byte(8'h55);
        wait_frame_sent();

        for (int i = 0; i < 4096; i++) begin
            push_pix(i % 64, i / 64, 8'(i), (i == 4095));
            rx_byte(8'(i));
            if (i % 512 == 0) check("hold_req_ready_recv", 32'(req_ready), 32'd0);
            repeat (i % 3) @(negedge clk);
        end
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("held_req_ready", 32'(req_ready), 32'd1);
        push_frame(16'h0100, 16'h0200, 16'h0004);
        @(negedge clk);
        req_valid = 1'b0;

        // Frame B: 100 bytes then silence -> timeout
        wait_frame_sent();
        for (int i = 0; i < 100; i++) begin
            push_pix(i % 64, i / 64, 8'(i + 7), 1'b0);
            rx_byte(8'(i + 7));
            @(negedge clk);
        end
        to_armed = 1'b1;
        k = 0;
        while (!to_seen && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout_seen", 32'(to_seen), 32'd1);
        @(negedge clk);
        check("timeout_single_pulse", 32'(err_timeout), 32'd0);
        check("timeout_idle_busy", 32'(busy), 32'd0);
        check("timeout_idle_req_ready", 32'(req_ready), 32'd1);

        // Frame C: restart at (0,0), then reset mid-receive
        send_req(16'h1234, 16'hABCD, 16'h0F0F);
        wait_frame_sent();
        for (int i = 0; i < 5; i++) begin
            push_pix(i, 0, 8'(8'hA0 + i), 1'b0);
            rx_byte(8'(8'hA0 + i));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_recv");
        check("reset_recv_pix_drained", 32'(exp_pix.size()), 32'd0);
        exp_pix.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Frame D: reset during the third byte of the frame
        send_req(16'h0102, 16'h0304, 16'h0506);
        wait_tx_left(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_send");
        exp_tx.delete();
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Frame E: normal operation resumes after reset
        send_req(16'h0000, 16'h0000, 16'h0001);
        wait_frame_sent();
        for (int i = 0; i < 3; i++) begin
            push_pix(i, 0, 8'(8'h10 + i), 1'b0);
            rx_byte(8'(8'h10 + i));
        end
        repeat (3) @(negedge clk);
        check("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
